// File: rtl/onehot_decoder_pipe.sv
// rtl/onehot_decoder_pipe.sv - index to one-hot/thermometer decoder with 2-entry skid buffer (optional DEC_ERR_CNT_EN error counter)
module onehot_decoder_pipe #(
   parameter int SEL_W = 3,
   parameter int OUT_W = 1 << SEL_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [SEL_W-1:0] in_sel,
   input  logic             in_mode,
   input  logic             in_en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_vec,
   output logic             out_err
`ifdef DEC_ERR_CNT_EN
   ,
   output logic [7:0]       err_cnt
`endif
);

   // Buffer occupancy: main register is the output, skid register holds overflow.
   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

   // Index compared one bit wider so OUT_W == 2**SEL_W never reports an error.
   localparam logic [SEL_W:0] OUT_LIMIT = (SEL_W + 1)'(OUT_W);

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [OUT_W-1:0] dec_vec;
   logic             dec_err;
   logic [OUT_W-1:0] skid_vec;
   logic             skid_err;
   logic             accept;
   logic             emit;

   assign accept = in_valid & in_ready;
   assign emit   = out_valid & out_ready;

   // Decode the incoming beat; only ever feeds registers, never the outputs directly.
   always_comb begin
      dec_vec = '0;
      dec_err = 1'b0;
      if (in_en) begin
         if ({1'b0, in_sel} >= OUT_LIMIT) begin
            dec_err = 1'b1;
         end else begin
            for (int i = 0; i < OUT_W; i++) begin
               if (in_mode) begin
                  dec_vec[i] = (i <= int'(in_sel));
               end else begin
                  dec_vec[i] = (i == int'(in_sel));
               end
            end
         end
      end
   end

   // Occupancy transitions; TWO cannot accept because in_ready is low there.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_EMPTY: begin
            if (accept) begin
               state_nxt = ST_ONE;
            end
         end
         ST_ONE: begin
            if (emit && !accept) begin
               state_nxt = ST_EMPTY;
            end else if (accept && !emit) begin
               state_nxt = ST_TWO;
            end
         end
         ST_TWO: begin
            if (emit) begin
               state_nxt = ST_ONE;
            end
         end
         default: state_nxt = ST_EMPTY;
      endcase
   end

   // State plus registered handshake flags, derived from the next occupancy so
   // in_ready depends only on flops and never on out_ready combinationally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_EMPTY;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         in_ready  <= (state_nxt != ST_TWO);
         out_valid <= (state_nxt != ST_EMPTY);
      end
   end

   // Main (output) register: refilled from skid when draining TWO, else from decoder.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vec <= '0;
         out_err <= 1'b0;
      end else if ((state == ST_TWO) && emit) begin
         out_vec <= skid_vec;
         out_err <= skid_err;
      end else if (accept && ((state == ST_EMPTY) || emit)) begin
         out_vec <= dec_vec;
         out_err <= dec_err;
      end
   end

   // Skid register: captures a beat that arrives while the output is stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_vec <= '0;
         skid_err <= 1'b0;
      end else if (accept && (state == ST_ONE) && !emit) begin
         skid_vec <= dec_vec;
         skid_err <= dec_err;
      end
   end

`ifdef DEC_ERR_CNT_EN
   // Saturating count of emitted error beats.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt <= 8'd0;
      end else if (emit && out_err && (err_cnt != 8'hFF)) begin
         err_cnt <= err_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_onehot_decoder_pipe.sv
// tb/tb_onehot_decoder_pipe.sv - scoreboard bench for onehot_decoder_pipe (8-wide and 6-wide instances)
module tb_onehot_decoder_pipe;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       a_in_valid = 1'b0, a_in_ready, a_in_mode = 1'b0, a_in_en = 1'b0;
   logic [2:0] a_in_sel = '0;
   logic       a_out_valid, a_out_ready = 1'b0, a_out_err;
   logic [7:0] a_out_vec;

   logic       b_in_valid = 1'b0, b_in_ready, b_in_mode = 1'b0, b_in_en = 1'b0;
   logic [2:0] b_in_sel = '0;
   logic       b_out_valid, b_out_ready = 1'b0, b_out_err;
   logic [5:0] b_out_vec;

`ifdef DEC_ERR_CNT_EN
   logic [7:0] a_err_cnt, b_err_cnt;
`endif

   int n_vec = 0;
   int n_bad = 0;
   logic [8:0] q_a[$];
   logic [8:0] q_b[$];

   always #5 clk = ~clk;

   onehot_decoder_pipe #(.SEL_W(3), .OUT_W(8)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_sel(a_in_sel),
      .in_mode(a_in_mode), .in_en(a_in_en),
      .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_vec(a_out_vec), .out_err(a_out_err)
`ifdef DEC_ERR_CNT_EN
      , .err_cnt(a_err_cnt)
`endif
   );

   onehot_decoder_pipe #(.SEL_W(3), .OUT_W(6)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sel(b_in_sel),
      .in_mode(b_in_mode), .in_en(b_in_en),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_vec(b_out_vec), .out_err(b_out_err)
`ifdef DEC_ERR_CNT_EN
      , .err_cnt(b_err_cnt)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitors: pop expected beat on every output handshake; also verify stall stability.
   logic       a_stalled = 1'b0, b_stalled = 1'b0;
   logic [8:0] a_held, b_held;
   always @(negedge clk) begin
      if (rst_n) begin
         if (a_stalled) check("a_hold", {a_out_valid, a_out_err, a_out_vec}, {1'b1, a_held});
         if (b_stalled) check("b_hold", {b_out_valid, b_out_err, 2'b00, b_out_vec}, {1'b1, b_held});
         if (a_out_valid && a_out_ready) begin
            if (q_a.size() == 0) check("a_unexpected_beat", {a_out_err, a_out_vec}, 32'h1FF);
            else check("a_beat", {a_out_err, a_out_vec}, q_a.pop_front());
         end
         if (b_out_valid && b_out_ready) begin
            if (q_b.size() == 0) check("b_unexpected_beat", {b_out_err, b_out_vec}, 32'h1FF);
            else check("b_beat", {b_out_err, 2'b00, b_out_vec}, q_b.pop_front());
         end
         a_stalled = a_out_valid && !a_out_ready;
         a_held    = {a_out_err, a_out_vec};
         b_stalled = b_out_valid && !b_out_ready;
         b_held    = {b_out_err, 2'b00, b_out_vec};
      end else begin
         a_stalled = 1'b0;
         b_stalled = 1'b0;
      end
   end

   // Issue one beat (called just after a rising edge); returns cycles stalled on in_ready.
   task automatic send(input bit to_b, input int sel, input bit mode, input bit en,
                       input bit exp_err, input logic [7:0] exp_vec, output int stalls);
      logic r;
      stalls = 0;
      if (to_b) begin
         b_in_valid = 1'b1; b_in_sel = 3'(sel); b_in_mode = mode; b_in_en = en;
      end else begin
         a_in_valid = 1'b1; a_in_sel = 3'(sel); a_in_mode = mode; a_in_en = en;
      end
      forever begin
         @(negedge clk);
         r = to_b ? b_in_ready : a_in_ready;
         @(posedge clk);
         if (r) begin
            if (to_b) q_b.push_back({exp_err, exp_vec});
            else      q_a.push_back({exp_err, exp_vec});
            break;
         end
         stalls++;
         if (stalls > 50) begin
            check("send_timeout", 32'(stalls), 32'd0);
            break;
         end
      end
      #1;
      a_in_valid = 1'b0;
      b_in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   int st, tot;

   initial begin
      #12;
      check("rst_a_out_valid", a_out_valid, 0);
      check("rst_a_out_vec", a_out_vec, 0);
      check("rst_a_out_err", a_out_err, 0);
      check("rst_a_in_ready", a_in_ready, 1);
`ifdef DEC_ERR_CNT_EN
      check("rst_err_cnt", a_err_cnt, 0);
`endif
      rst_n = 1'b1;
      idle(2);

      // 1: single one-hot, latency one cycle
      a_out_ready = 1'b1;
      send(0, 2, 0, 1, 0, 8'b00000100, st);
      check("t1_out_valid_next_cycle", a_out_valid, 1);
      check("t1_out_vec", a_out_vec, 8'b00000100);
      idle(2);

      // 2: back-to-back, no stalls
      tot = 0;
      send(0, 3, 0, 1, 0, 8'b00001000, st); tot += st;
      check("t2_valid_c1", a_out_valid, 1);
      send(0, 1, 0, 1, 0, 8'b00000010, st); tot += st;
      check("t2_valid_c2", a_out_valid, 1);
      send(0, 7, 0, 1, 0, 8'b10000000, st); tot += st;
      check("t2_valid_c3", a_out_valid, 1);
      check("t2_in_ready_stalls", tot, 0);
      check("t2_in_ready", a_in_ready, 1);
      idle(2);

      // 3: thermometer, enable off, thermometer boundaries
      send(0, 5, 1, 1, 0, 8'b00111111, st);
      send(0, 5, 1, 0, 0, 8'b00000000, st);
      send(0, 0, 1, 1, 0, 8'b00000001, st);
      send(0, 7, 1, 1, 0, 8'b11111111, st);
      send(0, 0, 0, 1, 0, 8'b00000001, st);
      idle(3);
      check("t3_drained", a_out_valid, 0);

      // 4: stall fills skid, then drain in order
      a_out_ready = 1'b0;
      send(0, 4, 0, 1, 0, 8'b00010000, st);
      send(0, 1, 1, 1, 0, 8'b00000011, st);
      check("t4_in_ready_low", a_in_ready, 0);
      check("t4_main_holds_first", a_out_vec, 8'b00010000);
      idle(2);
      check("t4_still_full", a_in_ready, 0);
      a_out_ready = 1'b1;
      idle(1);
      check("t4_in_ready_back", a_in_ready, 1);
      check("t4_second_presented", a_out_vec, 8'b00000011);
      idle(2);
      check("t4_queue_empty", q_a.size(), 0);

      // 5: OUT_W=6 out-of-range detection and counter saturation
      b_out_ready = 1'b1;
      send(1, 5, 0, 1, 0, 8'b00100000, st);
      send(1, 6, 0, 1, 1, 8'b00000000, st);
      send(1, 7, 1, 1, 1, 8'b00000000, st);
      send(1, 7, 0, 0, 0, 8'b00000000, st);
      idle(3);
`ifdef DEC_ERR_CNT_EN
      check("t5_err_cnt_2", b_err_cnt, 2);
`endif
      for (int i = 0; i < 298; i++) send(1, 6 + (i % 2), i % 2, 1, 1, 8'b00000000, st);
      idle(3);
`ifdef DEC_ERR_CNT_EN
      check("t5_err_cnt_sat", b_err_cnt, 255);
`endif
      check("t5_queue_empty", q_b.size(), 0);

      // 6: async reset while full discards everything
      a_out_ready = 1'b0;
      send(0, 6, 0, 1, 0, 8'b01000000, st);
      send(0, 2, 0, 1, 0, 8'b00000100, st);
      check("t6_full", a_in_ready, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_out_valid", a_out_valid, 0);
      check("t6_rst_in_ready", a_in_ready, 1);
      check("t6_rst_out_vec", a_out_vec, 0);
      q_a.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      a_out_ready = 1'b1;
      idle(1);
      send(0, 0, 0, 1, 0, 8'b00000001, st);
      check("t6_post_vec", a_out_vec, 8'b00000001);
      idle(4);
      check("t6_no_stale_valid", a_out_valid, 0);
      check("t6_queue_empty", q_a.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
